fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_decode_queue_if.sv | 15 +
 rtl/fetch_queue_storage.sv | 28 ++
 rtl/fetch_decode_queue.sv | 119 +++++++++++
 tb/tb_fetch_decode_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: default widths and the fetch packet carried fetch -> decode.
package riscv_pkg;

    localparam int DEFAULT_XLEN               = 64;
    localparam int DEFAULT_INSTRUCTION_LENGTH = DEFAULT_XLEN / 2;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0]               pc;
        logic [DEFAULT_INSTRUCTION_LENGTH-1:0] instr;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Valid/ready packet channel between fetch, the fetch/decode queue and decode.
interface fetch_decode_queue_if
    import riscv_pkg::*;
#(
    parameter int XLEN               = DEFAULT_XLEN,
    parameter int INSTRUCTION_LENGTH = XLEN / 2
);
    logic                          valid;
    logic                          ready;
    logic [XLEN-1:0]               pc;
    logic [INSTRUCTION_LENGTH-1:0] instr;

    modport master (output valid, output pc, output instr, input ready);
    modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/fetch_queue_storage.sv
// Packet storage for the fetch/decode queue: one write port, one asynchronous read port.
module fetch_queue_storage
    import riscv_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter type packet_t = fetch_packet_t,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  packet_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output packet_t       rd_data
);

    // No reset: occupancy is tracked outside, so stale entries are never observed.
    packet_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode FIFO with flush. Define FETCH_DECODE_QUEUE_BYPASS_EN to let a packet
// arriving at an empty queue reach decode in the same cycle.
module fetch_decode_queue
    import riscv_pkg::*;
#(
    parameter int XLEN               = DEFAULT_XLEN,
    parameter int INSTRUCTION_LENGTH = XLEN / 2,
    parameter int DEPTH              = 4,
    localparam int PTR_W             = $clog2(DEPTH),
    localparam int CNT_W             = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [INSTRUCTION_LENGTH-1:0] in_instr,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [XLEN-1:0]               out_pc,
    output logic [INSTRUCTION_LENGTH-1:0] out_instr,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [CNT_W-1:0]              count
);

    typedef struct packed {
        logic [XLEN-1:0]               pc;
        logic [INSTRUCTION_LENGTH-1:0] instr;
    } packet_t;

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             stored_valid;
    logic             bypass_active;
    logic             push_en;
    logic             pop_en;
    packet_t          wr_data;
    packet_t          head_data;

    assign in_ready     = (count_reg != CNT_W'(DEPTH));
    assign stored_valid = (count_reg != '0);

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    assign bypass_active = !stored_valid && in_valid && !flush;
`else
    assign bypass_active = 1'b0;
`endif

    // A bypassed packet that decode takes immediately is never written into storage.
    assign pop_en  = stored_valid && out_ready;
    assign push_en = in_valid && in_ready && !(bypass_active && out_ready);

    assign wr_data.pc    = in_pc;
    assign wr_data.instr = in_instr;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push_en) begin
                tail_next = tail_reg + PTR_W'(1);
            end
            if (pop_en) begin
                head_next = head_reg + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    fetch_queue_storage #(
        .DEPTH    (DEPTH),
        .packet_t (packet_t)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_en && !flush),
        .wr_addr (tail_reg),
        .wr_data (wr_data),
        .rd_addr (head_reg),
        .rd_data (head_data)
    );

    always_comb begin
        out_valid = stored_valid || bypass_active;
        out_pc    = '0;
        out_instr = '0;
        if (stored_valid) begin
            out_pc    = head_data.pc;
            out_instr = head_data.instr;
        end else if (bypass_active) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: stimulus queues expected packets, a monitor pops and compares.
module tb_fetch_decode_queue;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;

    int   errors = 0;
    int   checks = 0;
    int   mc     = 0;
    exp_t exp_q[$];

    fetch_decode_queue_if #(.XLEN(XLEN), .INSTRUCTION_LENGTH(ILEN)) in_if ();
    fetch_decode_queue_if #(.XLEN(XLEN), .INSTRUCTION_LENGTH(ILEN)) out_if ();

    fetch_decode_queue #(
        .XLEN               (XLEN),
        .INSTRUCTION_LENGTH (ILEN),
        .DEPTH              (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_if.valid),
        .in_pc     (in_if.pc),
        .in_instr  (in_if.instr),
        .in_ready  (in_if.ready),
        .out_valid (out_if.valid),
        .out_pc    (out_if.pc),
        .out_instr (out_if.instr),
        .out_ready (out_if.ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [ILEN-1:0] instr_of(logic [XLEN-1:0] pc);
        return 32'h0000_0013 | {pc[11:0], 20'h0};
    endfunction

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and record what the queue is expected to accept.
    task automatic set_inputs(logic iv, logic [XLEN-1:0] pc, logic ordy, logic fl);
        logic acc, pop, byp;
        exp_t e;
        in_if.valid   = iv;
        in_if.pc      = pc;
        in_if.instr   = instr_of(pc);
        out_if.ready  = ordy;
        flush         = fl;
        acc = iv && !fl && (mc != DEPTH);
        pop = ordy && !fl && (mc != 0);
        byp = 1'b0;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
        byp = iv && !fl && (mc == 0) && ordy;
`endif
        if (acc) begin
            e.pc    = pc;
            e.instr = instr_of(pc);
            exp_q.push_back(e);
            $display("push pc=%0h instr=%0h", pc, instr_of(pc));
        end
        if (fl) mc = 0;
        else    mc = mc + int'(acc) - int'(pop) - int'(byp);
    endtask

    // Monitor: every handshake at decode must match the oldest expected packet.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc=%0h expected no packet", out_if.pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", out_if.pc, e.pc);
                    chk("pop_instr", {32'h0, out_if.instr}, {32'h0, e.instr});
                    $display("pop  pc=%0h instr=%0h", out_if.pc, out_if.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_inputs(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        mc  = 0;
        exp_q.delete();
        chk("rst_count", 64'(count), 0);
        chk("rst_in_ready", 64'(in_if.ready), 1);
        chk("rst_out_valid", 64'(out_if.valid), 0);
        chk("rst_out_pc", out_if.pc, 0);
        chk("rst_out_instr", 64'(out_if.instr), 0);

        // Single push, one-cycle latency
        set_inputs(1'b1, 64'h0, 1'b0, 1'b0);
        tick();
        chk("one_count", 64'(count), 1);
        chk("one_out_valid", 64'(out_if.valid), 1);
        chk("one_out_pc", out_if.pc, 64'h0);
        chk("one_out_instr", 64'(out_if.instr), 64'h13);
        set_inputs(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("drain_count", 64'(count), 0);
        chk("drain_out_valid", 64'(out_if.valid), 0);
        chk("drain_out_pc", out_if.pc, 0);

        // Fill to full, overflow push ignored
        for (int i = 0; i < 4; i++) begin
            set_inputs(1'b1, 64'(4 * i), 1'b0, 1'b0);
            tick();
        end
        chk("full_count", 64'(count), 4);
        chk("full_in_ready", 64'(in_if.ready), 0);
        chk("full_out_pc", out_if.pc, 64'h0);
        set_inputs(1'b1, 64'h10, 1'b0, 1'b0);
        tick();
        chk("overflow_count", 64'(count), 4);
        set_inputs(1'b1, 64'h50, 1'b1, 1'b0);
        chk("full_pop_in_ready", 64'(in_if.ready), 0);
        tick();
        chk("full_pop_count", 64'(count), 3);
        set_inputs(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("pre_stream_count", 64'(count), 2);

        // Concurrent push/pop, pointers wrap
        for (int i = 0; i < 10; i++) begin
            set_inputs(1'b1, 64'(32'h100 + 4 * i), 1'b1, 1'b0);
            tick();
            chk("stream_count", 64'(count), 2);
        end

        // Flush discards contents and same-cycle push/pop
        set_inputs(1'b1, 64'h200, 1'b0, 1'b0);
        tick();
        chk("pre_flush_count", 64'(count), 3);
        set_inputs(1'b1, 64'h300, 1'b1, 1'b1);
        tick();
        exp_q.delete();
        chk("flush_count", 64'(count), 0);
        chk("flush_out_valid", 64'(out_if.valid), 0);
        chk("flush_in_ready", 64'(in_if.ready), 1);
        set_inputs(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("post_flush_count", 64'(count), 0);

        // Reset mid-stream
        for (int i = 0; i < 4; i++) begin
            set_inputs(1'b1, 64'(32'h400 + 4 * i), 1'b0, 1'b0);
            tick();
        end
        chk("pre_rst_count", 64'(count), 4);
        rst = 1'b1;
        set_inputs(1'b0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        mc  = 0;
        exp_q.delete();
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_out_pc", out_if.pc, 0);
        chk("mid_rst_out_instr", 64'(out_if.instr), 0);
        chk("mid_rst_out_valid", 64'(out_if.valid), 0);
        chk("mid_rst_in_ready", 64'(in_if.ready), 1);

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
        set_inputs(1'b1, 64'h100, 1'b1, 1'b0);
        #1;
        chk("bypass_out_valid", 64'(out_if.valid), 1);
        chk("bypass_out_pc", out_if.pc, 64'h100);
        tick();
        set_inputs(1'b0, '0, 1'b0, 1'b0);
        chk("bypass_count", 64'(count), 0);
`else
        set_inputs(1'b1, 64'h100, 1'b1, 1'b0);
        #1;
        chk("nobypass_out_valid", 64'(out_if.valid), 0);
        tick();
        set_inputs(1'b0, '0, 1'b1, 1'b0);
        chk("nobypass_count", 64'(count), 1);
        chk("nobypass_out_pc", out_if.pc, 64'h100);
        tick();
        set_inputs(1'b0, '0, 1'b0, 1'b0);
        chk("nobypass_drain_count", 64'(count), 0);
`endif

        tick();
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
